// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus: two fetch requesters plus the ROM port.
// The arbiter connects through the slave modport; the requester/ROM side
// (the surrounding system or a testbench) uses the master modport.
interface imem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  // requester 0 (CPU fetch)
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;
  logic              rsp0_ready;

  // requester 1 (test/debug fetch)
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_err;
  logic              rsp1_ready;

  // ROM port
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_addr, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_valid, req1_addr, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output mem_ce, mem_addr,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_addr, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_valid, req1_addr, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  mem_ce, mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-requester instruction-memory arbiter in front of a combinational ROM.
// One transaction in flight: IDLE (grant) -> ACCESS (ROM read) -> RESP
// (hold response until the owner consumes it). Ties are broken round-robin.
// Misaligned addresses never touch the ROM and return err=1, data=0.
module imem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_reg;
  logic              last_grant_reg;
  logic              owner_reg;
  logic              hold_reg;      // suppresses grants in the first cycle after reset
  logic [DATA_W-1:0] data_reg;
  logic              err_reg;
  logic              mem_ce_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [1:0]        rsp_valid_reg;

  logic [1:0]        req_valid;
  logic [1:0]        rsp_ready;
  logic [1:0]        grant;
  logic              win;
  logic              can_grant;
  logic [ADDR_W-1:0] win_addr;
  logic              win_aligned;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // Grant decision: only in IDLE, never during or right after reset;
  // on a tie the requester not granted last wins.
  always_comb begin
    can_grant   = (state_reg == IDLE) && !hold_reg && !rst;
    win         = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
    win_addr    = win ? bus.req1_addr : bus.req0_addr;
    win_aligned = (win_addr[1:0] == 2'b00);
    grant       = 2'b00;
    if (can_grant && (req_valid != 2'b00)) begin
      grant = win ? 2'b10 : 2'b01;
    end
  end

  // Transaction FSM with registered ROM-port and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      hold_reg       <= 1'b1;
      data_reg       <= '0;
      err_reg        <= 1'b0;
      mem_ce_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      rsp_valid_reg  <= 2'b00;
    end else begin
      hold_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant != 2'b00) begin
            owner_reg      <= win;
            last_grant_reg <= win;
            // The ROM sees the address only when it is word aligned.
            mem_ce_reg     <= win_aligned;
            mem_addr_reg   <= win_aligned ? win_addr : '0;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_ce_reg   <= 1'b0;
          mem_addr_reg <= '0;
          if (mem_ce_reg) begin
            data_reg <= bus.mem_rdata;
            err_reg  <= 1'b0;
          end else begin
            data_reg <= '0;
            err_reg  <= 1'b1;
          end
          rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_reg]) begin
            rsp_valid_reg <= 2'b00;
            data_reg      <= '0;
            err_reg       <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted; response payload is
  // only visible on the owner's channel while its valid is high.
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign bus.rsp0_valid = rsp_valid_reg[0] && !rst;
  assign bus.rsp1_valid = rsp_valid_reg[1] && !rst;
  assign bus.rsp0_data  = bus.rsp0_valid ? data_reg : '0;
  assign bus.rsp1_data  = bus.rsp1_valid ? data_reg : '0;
  assign bus.rsp0_err   = bus.rsp0_valid && err_reg;
  assign bus.rsp1_err   = bus.rsp1_valid && err_reg;

  assign bus.mem_ce   = mem_ce_reg && !rst;
  assign bus.mem_addr = rst ? '0 : mem_addr_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios followed by random traffic.
// A transaction-level model predicts grants, ROM accesses and responses;
// expected responses are queued at grant time and popped by the monitor.
module tb_imem_arbiter;
  localparam int AW = 64;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // ROM contents: a fixed scramble of the word address.
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2] * 32'h9E37_79B1;
    return w ^ 32'h1357_9BDF ^ a[63:32];
  endfunction

  assign bif.mem_rdata = bif.mem_ce ? rom_word(bif.mem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    int          owner;
    logic [63:0] addr;
    logic [31:0] data;
    logic        err;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model + monitor ----------------
  bit          txn_open = 1'b0;
  int          grant_cyc = 0;
  int          m_owner = 0;
  logic [63:0] m_addr = '0;
  bit          m_last = 1'b1;
  bit          prev_rst = 1'b1;

  initial begin
    bit [1:0] v;
    int       w;
    bit       exp_ce;
    bit       aligned;
    txn_t     t;
    forever begin
      @(negedge clk);
      cyc++;
      v = {bif.req1_valid, bif.req0_valid};
      w = -1;
      if (!rst && !prev_rst && !txn_open && v != 2'b00)
        w = (v == 2'b11) ? (m_last ? 0 : 1) : (v[1] ? 1 : 0);
      check("req0_ready", 64'(bif.req0_ready), 64'(w == 0));
      check("req1_ready", 64'(bif.req1_ready), 64'(w == 1));

      aligned = (m_addr[1:0] == 2'b00);
      exp_ce  = !rst && txn_open && (cyc == grant_cyc + 1) && aligned;
      check("mem_ce", 64'(bif.mem_ce), 64'(exp_ce));
      check("mem_addr", bif.mem_addr, exp_ce ? m_addr : 64'h0);

      for (int i = 0; i < 2; i++) begin
        logic        rv, re, rr;
        logic [31:0] rd;
        bit          ev;
        rv = (i == 1) ? bif.rsp1_valid : bif.rsp0_valid;
        re = (i == 1) ? bif.rsp1_err   : bif.rsp0_err;
        rd = (i == 1) ? bif.rsp1_data  : bif.rsp0_data;
        rr = (i == 1) ? bif.rsp1_ready : bif.rsp0_ready;
        ev = !rst && txn_open && (cyc >= grant_cyc + 2) && (m_owner == i);
        check($sformatf("rsp%0d_valid", i), 64'(rv), 64'(ev));
        if (rv === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL rsp%0d_unexpected: got valid=1, expected no pending response (cycle %0d)", i, cyc);
          end else begin
            check($sformatf("rsp%0d_owner", i), 64'(i), 64'(sb[0].owner));
            check($sformatf("rsp%0d_data", i), 64'(rd), 64'(sb[0].data));
            check($sformatf("rsp%0d_err", i), 64'(re), 64'(sb[0].err));
          end
        end else begin
          check($sformatf("rsp%0d_data_idle", i), 64'(rd), 64'h0);
          check($sformatf("rsp%0d_err_idle", i), 64'(re), 64'h0);
        end
        if (ev && rr === 1'b1 && sb.size() != 0) begin
          $display("txn req%0d addr=0x%0h data=0x%08h err=%0b done cycle %0d",
                   i, sb[0].addr, sb[0].data, sb[0].err, cyc);
          void'(sb.pop_front());
          txn_open = 1'b0;
        end
      end

      if (w >= 0) begin
        t.owner = w;
        t.addr  = (w == 1) ? bif.req1_addr : bif.req0_addr;
        t.err   = (t.addr[1:0] != 2'b00);
        t.data  = t.err ? 32'h0 : rom_word(t.addr);
        sb.push_back(t);
        txn_open  = 1'b1;
        grant_cyc = cyc;
        m_owner   = w;
        m_addr    = t.addr;
        m_last    = (w == 1);
      end

      if (rst) begin
        txn_open = 1'b0;
        sb.delete();
        m_last = 1'b1;
      end
      prev_rst = rst;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic issue(input int r, input logic [63:0] a);
    bit got;
    got = 1'b0;
    if (r == 1) begin bif.req1_valid = 1'b1; bif.req1_addr = a; end
    else        begin bif.req0_valid = 1'b1; bif.req0_addr = a; end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (((r == 1) ? bif.req1_ready : bif.req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    step();
    if (r == 1) bif.req1_valid = 1'b0;
    else        bif.req0_valid = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL issue_timeout: req%0d addr=0x%0h got no grant, expected grant within 30 cycles", r, a);
    end
  endtask

  initial begin
    bit acc0, acc1;
    rst = 1'b1;
    bif.req0_valid = 1'b1; bif.req0_addr = 64'h0;
    bif.req1_valid = 1'b1; bif.req1_addr = 64'h4;
    bif.rsp0_ready = 1'b1; bif.rsp1_ready = 1'b1;

    // Reset with both requesting, then a held tie: grants 0,1,0,1.
    repeat (3) step();
    rst = 1'b0;
    repeat (13) step();
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    repeat (2) step();

    // Single aligned fetch.
    issue(0, 64'h8);
    repeat (4) step();

    // Backpressure on requester 1 while requester 0 waits.
    bif.rsp1_ready = 1'b0;
    issue(1, 64'h10);
    bif.req0_valid = 1'b1;
    bif.req0_addr  = 64'h20;
    repeat (7) step();
    bif.rsp1_ready = 1'b1;
    issue(0, 64'h20);
    repeat (4) step();

    // Misaligned fetch.
    issue(0, 64'h6);
    repeat (4) step();

    // Reset during ACCESS, then a tie.
    issue(0, 64'hC);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.req0_valid = 1'b1; bif.req0_addr = 64'h40;
    bif.req1_valid = 1'b1; bif.req1_addr = 64'h44;
    repeat (4) step();
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    repeat (4) step();

    // Random traffic; a pending request is held until accepted.
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (!(bif.req0_valid && !acc0)) begin
        bif.req0_valid = ($urandom % 3) == 0;
        bif.req0_addr  = {$urandom, $urandom};
        bif.req0_addr[1:0] = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
      end
      if (!(bif.req1_valid && !acc1)) begin
        bif.req1_valid = ($urandom % 3) == 0;
        bif.req1_addr  = {$urandom, $urandom};
        bif.req1_addr[1:0] = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
      end
      bif.rsp0_ready = ($urandom % 4) != 0;
      bif.rsp1_ready = ($urandom % 4) != 0;
      rst = ($urandom % 100) == 0;
      @(negedge clk);
      acc0 = bif.req0_ready;
      acc1 = bif.req1_ready;
      step();
    end

    rst = 1'b0;
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    bif.rsp0_ready = 1'b1;
    bif.rsp1_ready = 1'b1;
    repeat (6) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
